cell_rle_loader: RTL
====================

// Module: cell_rle_loader
// PURPOSE
// Writer side of the 1-bit cell-state RAM: decodes a run-length token stream into
// row-major per-cell writes (addr = y*COLS + x), one cell per clock. Seeds the
// evolution RAM with an initial board before Round/vga consume it. Sits on the
// clk_vga domain; its write port is muxed into the RAM address/data/wren by the top.
// PARAMETERS
// COLS    40  board width in cells (x range 0..COLS-1)
// ROWS    30  board height in cells (y range 0..ROWS-1)
// ADDR_W  24  RAM address width; COLS*ROWS must fit
// RUN_W   8   token run-length width
// PORTS
// clk           in   1       pixel/system clock, all logic on rising edge
// rst_n         in   1       asynchronous active-low reset
// start         in   1       1-cycle pulse: begin loading a frame at address 0
// tok_valid     in   1       token present
// tok_ready     out  1       loader accepts token this cycle
// tok_run       in   RUN_W   number of cells to write (0 = no cells)
// tok_live      in   1       value written for the run
// tok_eol       in   1       after run, pad rest of current row with 0
// tok_last      in   1       after run/eol, pad rest of frame with 0, then finish
// wr_en         out  1       RAM write enable
// wr_addr       out  ADDR_W  RAM write address
// wr_data       out  1       RAM write data
// busy          out  1       high from cycle after start until done
// done          out  1       1-cycle pulse: frame complete
// err_overflow  out  1       sticky: a run exceeded the board; cleared by start
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, all outputs 0, counters x=y=addr=0.
// - States: IDLE -> ACCEPT (on start) -> RUN -> EOL_PAD -> TAIL_PAD -> DONE -> IDLE.
// - IDLE: tok_ready=0; start resets x,y,addr to 0, clears err_overflow, go ACCEPT.
//   start outside IDLE is ignored.
// - ACCEPT: tok_ready=1; token taken on tok_valid&tok_ready, latched; next state RUN.
//   No write in an ACCEPT cycle; first write of a token is the following cycle.
// - RUN: wr_en=1, wr_data=tok_live, wr_addr=addr, one cell per cycle for tok_run cells.
//   After each write: x++; x==COLS-1 wraps to x=0, y++. addr is a running counter
//   (no multiplier). tok_run=0 -> skips RUN, no write.
// - EOL_PAD (if tok_eol and x!=0): write 0 until x wraps to 0. x==0 -> no pad.
// - TAIL_PAD (if tok_last): write 0 until cell COLS*ROWS-1 written.
// - After a token without tok_last, return to ACCEPT unless board is full.
// - Board full (cell COLS*ROWS-1 written) in any state: go DONE; remaining run
//   or eol cells are discarded; err_overflow=1 if discarded run cells >0 (eol/tail
//   padding never flags). No write address ever exceeds COLS*ROWS-1.
// - DONE: done=1 for exactly one cycle, busy=0 the same cycle, then IDLE.
// - busy=1 in ACCEPT/RUN/EOL_PAD/TAIL_PAD. tok_ready=0 outside ACCEPT.
// - Reset mid-frame: writes stop immediately (wr_en=0 asynchronously), partial frame
//   left in RAM; next start reloads from address 0.
// TESTING (COLS=4, ROWS=2 unless stated)
// 1. start; tok{run=3,live=1,last} -> addr0-2=1, addr3-7=0, 8 consecutive wr_en
//    cycles, done pulse the cycle after addr7, err_overflow=0.
// 2. tok{2,1,eol}, tok{1,1,last} -> addr0,1=1; 2,3=0; 4=1; 5-7=0; done once.
// 3. tok{5,1}, tok{3,0} -> addr0-4=1 crossing row at x=3->0,y=1; addr5-7=0; done
//    without tok_last; tok_ready stays 0 after done.
// 4. tok{10,1} -> addr0-7=1, err_overflow=1 sticky, done; next start clears it.
// 5. tok_valid held while in RUN -> tok_ready=0, token not consumed; tok{0,1} ->
//    consumed, no write; start pulse during RUN ignored (addr continues).
// 6. rst_n=0 during RUN at addr3 -> wr_en/busy 0 at once; release, start,
//    tok{1,1,last} -> writes restart at addr0.

Source files
------------

// File: rtl/cell_rle_loader.sv
// ---------------------------------------------------------------------------
// cell_rle_loader
//
// Writer side of the 1-bit cell-state RAM. Decodes a run-length token stream
// into row-major per-cell writes (addr = y*COLS + x), one cell per clock, so
// an initial board can be seeded before the evolution logic and the VGA
// scan-out start reading it. The top muxes wr_en/wr_addr/wr_data onto the RAM.
//
// Ports
//   clk          : system/pixel clock, all logic on the rising edge
//   rst_n        : asynchronous active-low reset
//   start        : 1-cycle pulse, begin loading a frame at address 0 (IDLE only)
//   tok_valid    : token present on tok_run/tok_live/tok_eol/tok_last
//   tok_ready    : loader accepts a token this cycle
//   tok_run      : number of cells to write with tok_live (0 = none)
//   tok_live     : cell value for the run
//   tok_eol      : after the run, pad the rest of the current row with 0
//   tok_last     : after run/eol, pad the rest of the frame with 0 and finish
//   wr_en        : RAM write enable
//   wr_addr      : RAM write address
//   wr_data      : RAM write data
//   busy         : high while a frame is being loaded
//   done         : 1-cycle pulse when the frame is complete
//   err_overflow : sticky, a run did not fit on the board; cleared by start
// ---------------------------------------------------------------------------
module cell_rle_loader #(
   parameter int COLS   = 40,
   parameter int ROWS   = 30,
   parameter int ADDR_W = 24,
   parameter int RUN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              tok_valid,
   output logic              tok_ready,
   input  logic [RUN_W-1:0]  tok_run,
   input  logic              tok_live,
   input  logic              tok_eol,
   input  logic              tok_last,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_data,
   output logic              busy,
   output logic              done,
   output logic              err_overflow
);

   localparam int X_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int Y_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [X_W-1:0] X_MAX = X_W'(COLS - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(ROWS - 1);

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      RUN,
      EOL_PAD,
      TAIL_PAD,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [ADDR_W-1:0] addr;
   logic [RUN_W-1:0]  run_left;
   logic              live_q;
   logic              eol_q;
   logic              last_q;
   logic              err_q;

   logic x_wrap;
   logic at_last_cell;
   logic writing;
   logic take;

   // The current write lands on the last column when x wraps; when that is
   // also the last row the board is complete after this cycle's write.
   assign x_wrap       = (x == X_MAX);
   assign at_last_cell = x_wrap && (y == Y_MAX);
   assign writing      = (state == RUN) || (state == EOL_PAD) || (state == TAIL_PAD);
   assign take         = (state == ACCEPT) && tok_valid;

   // State register. Reset is asynchronous so wr_en, which decodes from the
   // state, drops the moment rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Every write state checks for the last cell first so
   // the board can never be written past COLS*ROWS-1; leftover run or pad
   // cells are simply dropped. "Row finished after this write" is x_wrap.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = ACCEPT;
            end
         end
         ACCEPT: begin
            if (tok_valid) begin
               if (tok_run != '0) begin
                  state_next = RUN;
               end else if (tok_eol && (x != '0)) begin
                  state_next = EOL_PAD;
               end else if (tok_last) begin
                  state_next = TAIL_PAD;
               end else begin
                  state_next = ACCEPT;
               end
            end
         end
         RUN: begin
            if (at_last_cell) begin
               state_next = DONE;
            end else if (run_left == RUN_W'(1)) begin
               if (eol_q && !x_wrap) begin
                  state_next = EOL_PAD;
               end else if (last_q) begin
                  state_next = TAIL_PAD;
               end else begin
                  state_next = ACCEPT;
               end
            end
         end
         EOL_PAD: begin
            if (at_last_cell) begin
               state_next = DONE;
            end else if (x_wrap) begin
               state_next = last_q ? TAIL_PAD : ACCEPT;
            end
         end
         TAIL_PAD: begin
            if (at_last_cell) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Position counters, latched token and the overflow flag. addr is kept as
   // a running counter alongside x/y so no multiplier is needed. It stops on
   // the last cell so it never points outside the board.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x        <= '0;
         y        <= '0;
         addr     <= '0;
         run_left <= '0;
         live_q   <= 1'b0;
         eol_q    <= 1'b0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            err_q <= 1'b0;
         end
         if (take) begin
            run_left <= tok_run;
            live_q   <= tok_live;
            eol_q    <= tok_eol;
            last_q   <= tok_last;
         end
         if (writing && !at_last_cell) begin
            addr <= addr + ADDR_W'(1);
            if (x_wrap) begin
               x <= '0;
               y <= y + Y_W'(1);
            end else begin
               x <= x + X_W'(1);
            end
         end
         if (state == RUN) begin
            run_left <= run_left - RUN_W'(1);
            if (at_last_cell && (run_left > RUN_W'(1))) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   // Output decode, purely from the state so every output follows reset
   // immediately. Only RUN writes the token value; both pad states write 0.
   always_comb begin
      tok_ready    = 1'b0;
      wr_en        = 1'b0;
      wr_data      = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      wr_addr      = addr;
      err_overflow = err_q;
      case (state)
         ACCEPT: begin
            tok_ready = 1'b1;
            busy      = 1'b1;
         end
         RUN: begin
            wr_en   = 1'b1;
            wr_data = live_q;
            busy    = 1'b1;
         end
         EOL_PAD, TAIL_PAD: begin
            wr_en = 1'b1;
            busy  = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            tok_ready = 1'b0;
         end
      endcase
   end

endmodule
